// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: owns the PC, drives a ready-handshake
// instruction port, handles stall and branch redirect. Optional IF_SKID_BUFFER_EN adds a one-entry skid.
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus8,
    output logic        id_valid
);

    typedef enum logic [1:0] {BOOT, FETCH, DROP, SKID} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_inc;
    logic [31:0] redirect_pc;

`ifdef IF_SKID_BUFFER_EN
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
`endif

    assign pc_inc      = pc + 32'd4;
    assign redirect_pc = branch_target & ~32'h3;
    assign id_pc_plus8 = id_pc + 32'd8;

    // In FETCH imem_addr always equals pc; in DROP it holds the abandoned address while pc holds the target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= BOOT;
            pc             <= RESET_PC;
            imem_req       <= 1'b0;
            imem_addr      <= RESET_PC;
            id_instruction <= NOP_INSTR;
            id_pc          <= 32'h0;
            id_valid       <= 1'b0;
`ifdef IF_SKID_BUFFER_EN
            skid_instr     <= NOP_INSTR;
            skid_pc        <= 32'h0;
`endif
        end else begin
            case (state)
                BOOT: begin
                    state     <= FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end
                FETCH: begin
                    if (branch_taken) begin
                        id_valid       <= 1'b0;
                        id_instruction <= NOP_INSTR;
                        pc             <= redirect_pc;
                        if (imem_ready)
                            imem_addr <= redirect_pc;
                        else
                            state <= DROP;
                    end else if (imem_ready && !stall) begin
                        id_instruction <= imem_rdata;
                        id_pc          <= pc;
                        id_valid       <= 1'b1;
                        pc             <= pc_inc;
                        imem_addr      <= pc_inc;
                    end else if (imem_ready && stall) begin
`ifdef IF_SKID_BUFFER_EN
                        skid_instr <= imem_rdata;
                        skid_pc    <= pc;
                        pc         <= pc_inc;
                        imem_addr  <= pc_inc;
                        imem_req   <= 1'b0;
                        state      <= SKID;
`endif
                    end else if (!imem_ready && !stall) begin
                        id_valid       <= 1'b0;
                        id_instruction <= NOP_INSTR;
                    end
                end
                DROP: begin
                    if (branch_taken)
                        pc <= redirect_pc;
                    if (imem_ready) begin
                        state     <= FETCH;
                        imem_addr <= branch_taken ? redirect_pc : pc;
                    end
                end
`ifdef IF_SKID_BUFFER_EN
                SKID: begin
                    if (branch_taken) begin
                        id_valid       <= 1'b0;
                        id_instruction <= NOP_INSTR;
                        pc             <= redirect_pc;
                        imem_addr      <= redirect_pc;
                        imem_req       <= 1'b1;
                        state          <= FETCH;
                    end else if (!stall) begin
                        id_instruction <= skid_instr;
                        id_pc          <= skid_pc;
                        id_valid       <= 1'b1;
                        imem_req       <= 1'b1;
                        state          <= FETCH;
                    end
                end
`endif
                default: begin
                    state    <= BOOT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage (default build): directed steps plus randomized traffic,
// checked each cycle against a transaction-level fetch model.
module tb_if_id_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus8;
    logic        id_valid;

    int tests = 0;
    int fails = 0;

    if_id_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .id_instruction(id_instruction), .id_pc(id_pc), .id_pc_plus8(id_pc_plus8), .id_valid(id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0108) return 32'hE281_1001;
        return {a[15:0] ^ 16'hA5C3, ~a[31:16]} ^ {a[7:0], 24'h5A5A5A};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    // Reference: where the port points, where fetching continues, whether the
    // outstanding response is to be thrown away, and what decode currently holds.
    logic        m_booting;
    logic        m_req;
    logic [31:0] m_port_addr;
    logic [31:0] m_next;
    logic        m_discard;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_valid;

    task automatic model_reset();
        m_booting = 1'b1; m_req = 1'b0; m_port_addr = RST_PC; m_next = RST_PC;
        m_discard = 1'b0; m_instr = NOP; m_pc = 32'h0; m_valid = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        tgt = {branch_target[31:2], 2'b00};
        if (m_booting) begin
            m_booting = 1'b0;
            m_req = 1'b1;
            m_port_addr = m_next;
        end else if (m_discard) begin
            if (branch_taken) m_next = tgt;
            if (imem_ready) begin
                m_discard = 1'b0;
                m_port_addr = m_next;
            end
        end else if (branch_taken) begin
            m_valid = 1'b0; m_instr = NOP; m_next = tgt;
            if (imem_ready) m_port_addr = tgt;
            else m_discard = 1'b1;
        end else if (imem_ready && !stall) begin
            m_instr = mem_word(m_port_addr); m_pc = m_port_addr; m_valid = 1'b1;
            m_next = m_port_addr + 32'd4;
            m_port_addr = m_next;
        end else if (!imem_ready && !stall) begin
            m_valid = 1'b0; m_instr = NOP;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("imem_req", {31'h0, imem_req}, {31'h0, m_req});
        check("imem_addr", imem_addr, m_port_addr);
        check("id_instruction", id_instruction, m_instr);
        check("id_pc", id_pc, m_pc);
        check("id_pc_plus8", id_pc_plus8, m_pc + 32'd8);
        check("id_valid", {31'h0, id_valid}, {31'h0, m_valid});
    endtask

    task automatic cycle(input logic rdy, input logic stl, input logic br, input logic [31:0] tgt);
        imem_ready = rdy; stall = stl; branch_taken = br; branch_target = tgt;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Straight-line fetch from RESET_PC
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("t1_first_addr", imem_addr, 32'h0000_0100);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t1_id_pc", id_pc, 32'h0000_0100);
        check("t1_plus8", id_pc_plus8, 32'h0000_0108);
        check("t1_addr2", imem_addr, 32'h0000_0104);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t1_addr3", imem_addr, 32'h0000_0108);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Hold the word at 0x108 through a three-cycle stall
        check("t2_held_instr", id_instruction, 32'hE281_1001);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            check("t2_stall_instr", id_instruction, 32'hE281_1001);
            check("t2_stall_addr", imem_addr, 32'h0000_010C);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t2_resume_pc", id_pc, 32'h0000_010C);

        // Branch with ready, then branch under stall
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0203);
        check("t3_valid", {31'h0, id_valid}, 32'h0);
        check("t3_nop", id_instruction, 32'hE1A0_0000);
        check("t3_addr", imem_addr, 32'h0000_0200);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0300);
        check("t3_stall_flush", {31'h0, id_valid}, 32'h0);

        // Branch while not ready: old address held until ready, then target
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0400);
        check("t4_hold", imem_addr, 32'h0000_0300);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t4_target", imem_addr, 32'h0000_0400);
        check("t4_no_leak", {31'h0, id_valid}, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t4_fetched", id_pc, 32'h0000_0400);

        // Wrap at the top of the address space
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t5_wrap_addr", imem_addr, 32'h0000_0000);
        check("t5_wrap_plus8", id_pc_plus8, 32'h0000_0004);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, t);
        end

        // Asynchronous reset in the middle of DROP
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0800);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("t6_refetch", imem_addr, RST_PC);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
